// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters.
// Grants in IDLE, evaluates in EXEC, holds a registered response in RESP.
module alu_share_alu #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [1:0]      op,
  output logic [XLEN-1:0] alu_out,
  output logic            zero
);

  always_comb begin
    alu_out = '0;
    unique case (op)
      2'b00: alu_out = a + b;
      2'b01: alu_out = a - b;
      2'b10: alu_out = a & b;
      2'b11: alu_out = a | b;
      default: alu_out = '0;
    endcase
    zero = (alu_out == '0);
  end

endmodule

module alu_share_arbiter #(
  parameter int XLEN = 32,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
  input  logic [NREQ*2-1:0]    req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [XLEN-1:0]      rsp_data,
  output logic                 rsp_zero,
  output logic [15:0]          ops_done,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IDW-1:0]  last;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  cand;
  logic            grant_hit;
  int              idx;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic [1:0]      opc;
  logic [XLEN-1:0] alu_out;
  logic            alu_zero;
  logic            take;
  logic            fire;
  logic            bad;

  // Search starts just after the last winner so priority rotates.
  always_comb begin
    grant_hit = 1'b0;
    grant_id  = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx  = (int'(last) + k) % NREQ;
      cand = IDW'(idx);
      if (!grant_hit && req_valid[cand]) begin
        grant_hit = 1'b1;
        grant_id  = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (grant_hit && rst_n) begin
          req_ready[grant_id] = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign take = (state == IDLE) && grant_hit;
  assign fire = (state == RESP) && rsp_ready;
  assign bad  = !(state inside {IDLE, EXEC, RESP});

  alu_share_alu #(.XLEN(XLEN)) u_alu (
    .a       (opa),
    .b       (opb),
    .op      (opc),
    .alu_out (alu_out),
    .zero    (alu_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= IDW'(NREQ - 1);
      opa       <= '0;
      opb       <= '0;
      opc       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      ops_done  <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        opa    <= req_a[grant_id*XLEN +: XLEN];
        opb    <= req_b[grant_id*XLEN +: XLEN];
        opc    <= req_op[grant_id*2 +: 2];
        rsp_id <= grant_id;
        last   <= grant_id;
      end
      if (state == EXEC) begin
        rsp_data  <= alu_out;
        rsp_zero  <= alu_zero;
        rsp_valid <= 1'b1;
      end
      if (fire) begin
        rsp_valid <= 1'b0;
        if (ops_done != 16'hFFFF) ops_done <= ops_done + 16'd1;
      end
      if (bad) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed steps plus
// randomized transactions against a transaction-level reference model.
module tb_alu_share_arbiter;
  localparam int XLEN = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*XLEN-1:0] req_a = '0;
  logic [NREQ*XLEN-1:0] req_b = '0;
  logic [NREQ*2-1:0]    req_op = '0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [IDW-1:0]       rsp_id;
  logic [XLEN-1:0]      rsp_data;
  logic                 rsp_zero;
  logic [15:0]          ops_done;
  logic                 busy;

  alu_share_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero),
    .ops_done  (ops_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int m_last = NREQ - 1;
  int m_ops = 0;
  int last_acc = -100;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int lst);
    for (int k = 1; k <= NREQ; k++)
      if (v[(lst + k) % NREQ]) return (lst + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [XLEN-1:0] ref_alu(input logic [XLEN-1:0] a,
      input logic [XLEN-1:0] b, input logic [1:0] op);
    case (op)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: return a & b;
      default: return a | b;
    endcase
  endfunction

  task automatic set_req(input int i, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [1:0] op);
    req_a[i*XLEN +: XLEN] = a;
    req_b[i*XLEN +: XLEN] = b;
    req_op[i*2 +: 2] = op;
  endtask

  task automatic scramble();
    for (int i = 0; i < NREQ; i++)
      set_req(i, $urandom, $urandom, 2'($urandom_range(0, 3)));
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after
  // the response handshake.
  task automatic do_txn(input logic [NREQ-1:0] v, input int bp,
                        input bit hold, input bit spacing, output int gid);
    int g;
    logic [XLEN-1:0] ea, eb, ed;
    logic [1:0] eo;
    req_valid = v;
    #1;
    g = rr_pick(v, m_last);
    chk("grant", 64'(req_ready), 64'(1) << g);
    ea = req_a[g*XLEN +: XLEN];
    eb = req_b[g*XLEN +: XLEN];
    eo = req_op[g*2 +: 2];
    ed = ref_alu(ea, eb, eo);
    if (spacing) chk("spacing", 64'(cyc - last_acc), 64'd3);
    last_acc = cyc;
    m_last = g;
    gid = g;
    @(negedge clk);
    if (!hold) req_valid[g] = 1'b0;
    scramble();
    rsp_ready = 1'($urandom_range(0, 1));
    #1;
    chk("exec_busy", 64'(busy), 64'd1);
    chk("exec_valid", 64'(rsp_valid), 64'd0);
    chk("exec_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rsp_ready = (bp == 0);
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rsp_id", 64'(rsp_id), 64'(g));
    chk("rsp_data", 64'(rsp_data), 64'(ed));
    chk("rsp_zero", 64'(rsp_zero), 64'(ed == '0));
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_data", 64'(rsp_data), 64'(ed));
      chk("bp_id", 64'(rsp_id), 64'(g));
      chk("bp_ready", 64'(req_ready), 64'd0);
      chk("bp_ops", 64'(ops_done), 64'(m_ops));
      if (i == bp - 1) rsp_ready = 1'b1;
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    m_ops++;
    chk("done_valid", 64'(rsp_valid), 64'd0);
    chk("done_ops", 64'(ops_done), 64'(m_ops));
    chk("done_busy", 64'(busy), 64'd0);
    chk("done_id_kept", 64'(rsp_id), 64'(g));
    chk("done_data_kept", 64'(rsp_data), 64'(ed));
  endtask

  initial begin
    int gid;
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    logic [NREQ-1:0] v;

    // Reset with requests pending: nothing granted, outputs cleared.
    req_valid = 4'b1111;
    #3;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_id", 64'(rsp_id), 64'd0);
    chk("rst_data", 64'(rsp_data), 64'd0);
    chk("rst_zero", 64'(rsp_zero), 64'd0);
    chk("rst_ops", 64'(ops_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_no_req", 64'(req_ready), 64'd0);

    // Basic ADD then each opcode on assorted requesters.
    set_req(0, 32'd5, 32'd7, 2'b00);
    do_txn(4'b0001, 0, 0, 0, gid);
    chk("add_ops1", 64'(ops_done), 64'd1);
    set_req(1, 32'd9, 32'd9, 2'b01);
    do_txn(4'b0010, 0, 0, 0, gid);
    chk("sub_zero", 64'(rsp_zero), 64'd1);
    set_req(2, 32'hFFFF_FFFF, 32'd1, 2'b00);
    do_txn(4'b0100, 1, 0, 0, gid);
    chk("add_wrap", 64'(rsp_data), 64'd0);
    set_req(0, 32'h0000_F0F0, 32'h0000_0FF0, 2'b10);
    do_txn(4'b0001, 0, 0, 0, gid);
    chk("and", 64'(rsp_data), 64'h00F0);
    set_req(3, 32'h0000_F000, 32'h0000_000F, 2'b11);
    do_txn(4'b1000, 2, 0, 0, gid);
    chk("or", 64'(rsp_data), 64'hF00F);

    // All requesting continuously: rotating order, 3-cycle spacing.
    for (int i = 0; i < 5; i++) begin
      do_txn(4'b1111, 0, 1, i > 0, gid);
      chk("rr_order", 64'(gid), 64'(exp_seq[i]));
    end

    // Long backpressure with requests pending.
    do_txn(4'b1111, 5, 1, 0, gid);

    // Pointer wrap: 2 alone, then 0 and 2 together -> 0.
    req_valid = '0;
    do_txn(4'b0100, 0, 0, 0, gid);
    do_txn(4'b0101, 0, 0, 0, gid);
    chk("wrap_gid", 64'(gid), 64'd0);

    // Reset during EXEC discards the pending op.
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_ops", 64'(ops_done), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    m_last = NREQ - 1;
    m_ops = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_stale", 64'(rsp_valid), 64'd0);
    end
    do_txn(4'b1111, 0, 0, 0, gid);
    chk("post_rst_gid", 64'(gid), 64'd0);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        req_valid = '0;
        #1;
        chk("rand_idle", 64'(req_ready), 64'd0);
        @(negedge clk);
      end
      scramble();
      v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      do_txn(v, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, gid);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
